lbp_engine_param: RTL

//  Parametrised Local Binary Pattern engine for gray images of 2^COL_BITS x 2^ROW_BITS pixels.

---
 rtl/lbp_engine_param.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lbp_engine_param.sv
// -----------------------------------------------------------------------------
// lbp_engine_param
// Local Binary Pattern engine for a 2^COL_BITS x 2^ROW_BITS gray image.
// A 3x3 window is loaded with 9 reads at the first interior pixel of a row.
// For each later interior pixel it slides left and only the new right column
// (3 reads) is fetched. One code per pixel is emitted in raster order through
// a valid/ready handshake. Border pixels emit 0 without reading memory.
//
// Optional build macro: LBP_UNIFORM_MAP_EN
//   defined   -> lbp_data_o is the rotation-invariant uniform (riu2) label
//   undefined -> lbp_data_o is the raw 8-bit code
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   gray_ready_i   image available (sampled only in IDLE)
//   gray_req_o     read strobe for gray_addr_o
//   gray_addr_o    {row,col} read address
//   gray_data_i    read data, valid one cycle after a gray_req_o cycle
//   thr_i          neighbour threshold offset, latched at image start
//   lbp_ready_i    sink accepts the current output
//   lbp_valid_o    lbp_addr_o / lbp_data_o valid
//   lbp_addr_o     {row,col} of the current output pixel
//   lbp_data_o     LBP code (raw or riu2)
//   finish_o       whole image written; sticky until reset
// -----------------------------------------------------------------------------
module lbp_engine_param #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7,
  parameter int PIX_W    = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         gray_ready_i,
  output logic                         gray_req_o,
  output logic [ROW_BITS+COL_BITS-1:0] gray_addr_o,
  input  logic [PIX_W-1:0]             gray_data_i,
  input  logic [PIX_W-1:0]             thr_i,
  input  logic                         lbp_ready_i,
  output logic                         lbp_valid_o,
  output logic [ROW_BITS+COL_BITS-1:0] lbp_addr_o,
  output logic [7:0]                   lbp_data_o,
  output logic                         finish_o
);

  localparam int AW = ROW_BITS + COL_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [ROW_BITS-1:0] ROW_ZERO = {ROW_BITS{1'b0}};
  localparam logic [ROW_BITS-1:0] ROW_ONE  = {{(ROW_BITS-1){1'b0}}, 1'b1};
  localparam logic [ROW_BITS-1:0] ROW_MAX  = {ROW_BITS{1'b1}};
  localparam logic [COL_BITS-1:0] COL_ZERO = {COL_BITS{1'b0}};
  localparam logic [COL_BITS-1:0] COL_ONE  = {{(COL_BITS-1){1'b0}}, 1'b1};
  localparam logic [COL_BITS-1:0] COL_MAX  = {COL_BITS{1'b1}};

  // Window slots: 0 = centre, slot k+1 = neighbour feeding code bit k.
  // Grid layout:  1 2 3 / 4 0 5 / 6 7 8  (TL T TR / L C R / BL B BR)
  function automatic logic [AW-1:0] rd_addr(input logic [ROW_BITS-1:0] r,
                                            input logic [COL_BITS-1:0] c,
                                            input logic [3:0] slot);
    logic [ROW_BITS-1:0] ra;
    logic [COL_BITS-1:0] ca;
    case (slot)
      4'd1, 4'd2, 4'd3: ra = r - ROW_ONE;
      4'd6, 4'd7, 4'd8: ra = r + ROW_ONE;
      default:          ra = r;
    endcase
    case (slot)
      4'd1, 4'd4, 4'd6: ca = c - COL_ONE;
      4'd3, 4'd5, 4'd8: ca = c + COL_ONE;
      default:          ca = c;
    endcase
    return {ra, ca};
  endfunction

  // Slots of the right column fetched after a shift: TR, R, BR.
  function automatic logic [3:0] shift_slot(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'd3;
      4'd1:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_border(input logic [ROW_BITS-1:0] r,
                                     input logic [COL_BITS-1:0] c);
    return (r == ROW_ZERO) || (r == ROW_MAX) || (c == COL_ZERO) || (c == COL_MAX);
  endfunction

  // Threshold sum is one bit wider so centre+thr never wraps.
  function automatic logic [7:0] lbp_code(input logic [8:0][PIX_W-1:0] w,
                                          input logic [PIX_W-1:0] t);
    logic [PIX_W:0] ref_v;
    logic [7:0]     code;
    ref_v = {1'b0, w[0]} + {1'b0, t};
    for (int k = 0; k < 8; k++) begin
      code[k] = ({1'b0, w[k+1]} >= ref_v);
    end
    return code;
  endfunction

  // Uniform rotation-invariant label over the circular neighbour order
  // TL,T,TR,R,BR,B,BL,L.
  function automatic logic [7:0] riu2(input logic [7:0] c);
    logic [7:0] s;
    logic [7:0] diff;
    logic [3:0] u;
    logic [3:0] ones;
    s    = {c[3], c[5], c[6], c[7], c[4], c[2], c[1], c[0]};
    diff = s ^ {s[0], s[7:1]};
    u    = 4'd0;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      u    = u + {3'b000, diff[i]};
      ones = ones + {3'b000, c[i]};
    end
    if (u <= 4'd2) begin
      return {4'd0, ones};
    end else begin
      return 8'd9;
    end
  endfunction

  function automatic logic [7:0] lbp_map(input logic [7:0] c);
`ifdef LBP_UNIFORM_MAP_EN
    return riu2(c);
`else
    return c;
`endif
  endfunction

  logic [2:0]               state_q, state_d;
  logic [ROW_BITS-1:0]      row_q, row_d;
  logic [COL_BITS-1:0]      col_q, col_d;
  logic [3:0]               idx_q, idx_d;
  logic [PIX_W-1:0]         thr_q, thr_d;
  logic [8:0][PIX_W-1:0]    win_q, win_d;
  logic                     cap_vld_q, cap_vld_d;
  logic [3:0]               cap_slot_q, cap_slot_d;
  logic                     gray_req_q, gray_req_d;
  logic [AW-1:0]            gray_addr_q, gray_addr_d;
  logic                     lbp_valid_q, lbp_valid_d;
  logic [7:0]               lbp_data_q, lbp_data_d;
  logic                     finish_q, finish_d;
  logic                     enter_s;

  // Next-state logic: sequencing of reads, window updates and output handshake.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    idx_d       = idx_q;
    thr_d       = thr_q;
    win_d       = win_q;
    cap_vld_d   = 1'b0;
    cap_slot_d  = cap_slot_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    lbp_valid_d = lbp_valid_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    enter_s     = 1'b0;

    // Read data issued last cycle lands in its window slot now.
    if (cap_vld_q) begin
      win_d[cap_slot_q] = gray_data_i;
    end else begin
      win_d = win_q;
    end

    case (state_q)
      S_IDLE: begin
        if (gray_ready_i) begin
          thr_d   = thr_i;
          row_d   = ROW_ZERO;
          col_d   = COL_ZERO;
          enter_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        cap_vld_d  = 1'b1;
        cap_slot_d = idx_q;
        if (idx_q == 4'd8) begin
          state_d = S_DRAIN;
        end else begin
          idx_d       = idx_q + 4'd1;
          gray_req_d  = 1'b1;
          gray_addr_d = rd_addr(row_q, col_q, idx_q + 4'd1);
        end
      end
      S_SHIFT: begin
        cap_vld_d  = 1'b1;
        cap_slot_d = shift_slot(idx_q);
        if (idx_q == 4'd2) begin
          state_d = S_DRAIN;
        end else begin
          idx_d       = idx_q + 4'd1;
          gray_req_d  = 1'b1;
          gray_addr_d = rd_addr(row_q, col_q, shift_slot(idx_q + 4'd1));
        end
      end
      S_DRAIN: begin
        // Last (BR) sample is arriving; code uses the updated window.
        state_d     = S_EMIT;
        lbp_valid_d = 1'b1;
        lbp_data_d  = lbp_map(lbp_code(win_d, thr_q));
      end
      S_EMIT: begin
        if (lbp_ready_i) begin
          lbp_valid_d = 1'b0;
          if ((row_q == ROW_MAX) && (col_q == COL_MAX)) begin
            state_d  = S_FINISH;
            finish_d = 1'b1;
            row_d    = ROW_ZERO;
            col_d    = COL_ZERO;
          end else begin
            col_d   = col_q + COL_ONE;
            row_d   = (col_q == COL_MAX) ? (row_q + ROW_ONE) : row_q;
            enter_s = 1'b1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FINISH: begin
        finish_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Start work on the pixel at (row_d, col_d).
    if (enter_s) begin
      idx_d = 4'd0;
      if (is_border(row_d, col_d)) begin
        state_d     = S_EMIT;
        lbp_valid_d = 1'b1;
        lbp_data_d  = 8'd0;
      end else if (col_d == COL_ONE) begin
        state_d     = S_FILL;
        gray_req_d  = 1'b1;
        gray_addr_d = rd_addr(row_d, col_d, 4'd0);
      end else begin
        state_d     = S_SHIFT;
        gray_req_d  = 1'b1;
        gray_addr_d = rd_addr(row_d, col_d, 4'd3);
        // Slide left: column 1 -> 0, column 2 -> 1.
        win_d[1] = win_q[2];
        win_d[2] = win_q[3];
        win_d[4] = win_q[0];
        win_d[0] = win_q[5];
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      row_q       <= ROW_ZERO;
      col_q       <= COL_ZERO;
      idx_q       <= 4'd0;
      thr_q       <= {PIX_W{1'b0}};
      win_q       <= {(9*PIX_W){1'b0}};
      cap_vld_q   <= 1'b0;
      cap_slot_q  <= 4'd0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= {AW{1'b0}};
      lbp_valid_q <= 1'b0;
      lbp_data_q  <= 8'd0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      thr_q       <= thr_d;
      win_q       <= win_d;
      cap_vld_q   <= cap_vld_d;
      cap_slot_q  <= cap_slot_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  assign gray_req_o  = gray_req_q;
  assign gray_addr_o = gray_addr_q;
  assign lbp_valid_o = lbp_valid_q;
  assign lbp_addr_o  = {row_q, col_q};
  assign lbp_data_o  = lbp_data_q;
  assign finish_o    = finish_q;

endmodule
